// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
//   div_state_t      : sequencer states (free, by-zero, running, result held)
//   double_reg_bus_t : {hi, lo} register pair written back by EX
//   DIV_RESULT_*     : levels driven on ready_o
//   DIV_START/STOP   : levels sampled on start_i
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    typedef logic [63:0] double_reg_bus_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration (purely combinational).
//   rem_i     : current partial remainder (always < divisor_i)
//   divisor_i : divisor magnitude
//   bit_i     : next dividend bit shifted into the remainder
//   rem_o     : partial remainder after the trial subtraction
//   q_bit_o   : quotient bit produced by this iteration
module div_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // The shifted remainder can need WIDTH+1 bits, so the trial
    // subtraction is done one bit wider; its MSB is the borrow.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[WIDTH]) begin
            q_bit_o = 1'b1;
            rem_o   = diff[WIDTH-1:0];
        end else begin
            q_bit_o = 1'b0;
            rem_o   = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per clock; signed operands are divided as magnitudes
// and the signs are fixed up when the last bit is produced.
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   signed_div_i  : 1 = DIV (signed), 0 = DIVU
//   opdata1_i     : dividend, sampled only when an op is accepted
//   opdata2_i     : divisor, sampled only when an op is accepted
//   start_i       : request level, held by EX until the result is consumed
//   annul_i       : flush; abandons the in-flight op
//   result_o      : {remainder, quotient}, valid while ready_o = 1
//   ready_o       : result valid
//   div_zero_o    : completed op had a zero divisor
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_zero_o
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;       // dividend bits still to consume, quotient fills from LSB
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic [WIDTH-1:0] rem;       // partial remainder
    logic             sign1;
    logic             sign2;
    logic             signed_op;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quot_final;

    // abs(most negative) wraps back to itself, which read unsigned is
    // exactly the magnitude we need.
    function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] neg;
        neg = -x;
        return (x < 0) ? $unsigned(neg) : $unsigned(x);
    endfunction

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem),
        .divisor_i (dvs),
        .bit_i     (dvd[WIDTH-1]),
        .rem_o     (rem_next),
        .q_bit_o   (q_bit)
    );

    assign quot_final = {dvd[WIDTH-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DIV_FREE;
            cnt        <= '0;
            result_o   <= '0;
            ready_o    <= DIV_RESULT_NOT_READY;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state     <= DIV_ON;
                            dvd       <= signed_div_i ? mag_of(opdata1_i) : opdata1_i;
                            dvs       <= signed_div_i ? mag_of(opdata2_i) : opdata2_i;
                            sign1     <= opdata1_i[WIDTH-1];
                            sign2     <= opdata2_i[WIDTH-1];
                            signed_op <= signed_div_i;
                            rem       <= '0;
                            cnt       <= '0;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state      <= DIV_END;
                    result_o   <= '0;
                    div_zero_o <= 1'b1;
                    ready_o    <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    // Annul or a dropped request wins over the final iteration.
                    if (annul_i || start_i == DIV_STOP) begin
                        state   <= DIV_FREE;
                        ready_o <= DIV_RESULT_NOT_READY;
                    end else begin
                        rem <= rem_next;
                        dvd <= quot_final;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH-1)) begin
                            state <= DIV_END;
                            result_o[WIDTH-1:0] <= (signed_op && (sign1 != sign2))
                                                   ? negate(quot_final) : quot_final;
                            result_o[2*WIDTH-1:WIDTH] <= (signed_op && sign1)
                                                   ? negate(rem_next) : rem_next;
                            ready_o    <= DIV_RESULT_READY;
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                DIV_END: begin
                    if (annul_i || start_i == DIV_STOP) begin
                        state      <= DIV_FREE;
                        result_o   <= '0;
                        ready_o    <= DIV_RESULT_NOT_READY;
                        div_zero_o <= 1'b0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
Multi-cycle radix-2 restoring divider sequencer serving DIV/DIVU in the EX stage. EX raises start_i and holds stallreq_from_ex asserted while start_i is high and ready_o is low. On ready_o, EX writes {hi, lo} = result_o. Produces one quotient bit per cycle and handles signed conversion, divide-by-zero and pipeline annul.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
opdata1_i  in  WIDTH  dividend (rs)
opdata2_i  in  WIDTH  divisor (rt)
start_i  in  1  request; level, held by EX until result consumed
annul_i  in  1  cancel in-flight operation (flush)
result_o  out  2*WIDTH  {remainder, quotient}; valid only while ready_o=1
ready_o  out  1  result valid
div_zero_o  out  1  last completed op had divisor 0; valid with ready_o

Behaviour:
- Reset: rst is synchronous, active-high. It forces state=IDLE, cnt=0, result_o=0, ready_o=0, div_zero_o=0. Reset mid-operation abandons the op with no residual state.
- States (2-bit): IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i==0: go to BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0: go to ON. Latch abs(opdata1_i) and abs(opdata2_i) when signed_div_i=1, raw values otherwise. Latch sign1, sign2 and signed_div_i. Clear the partial remainder and set cnt=0.
  - Otherwise stay in IDLE with ready_o=0.
- BYZERO: always go to END next edge. result_o=0, div_zero_o=1, ready_o=1. Ready therefore rises 2 edges after the start-sampling edge.
- ON, one iteration per edge:
  - Shift the partial remainder left 1, bringing in the next dividend MSB.
  - Compare as WIDTH+1 bits. If the shifted remainder >= divisor, subtract and set quotient bit 1; else quotient bit 0.
  - cnt increments.
  - On the iteration with cnt==WIDTH-1, go to END and register sign-corrected results: quotient negated (two's complement) if signed and sign1!=sign2; remainder negated if signed and sign1=1. Set ready_o=1 and div_zero_o=0.
  - Ready therefore rises WIDTH+1 (33) edges after the start-sampling edge.
- ON with annul_i=1 or start_i=0: go to IDLE on that edge, ready_o stays 0, and no result is produced. Annul takes priority over the final iteration.
- END:
  - Hold result_o, ready_o=1, div_zero_o while start_i=1.
  - start_i=0 or annul_i=1: go to IDLE and clear ready_o, result_o and div_zero_o on that edge.
  - A new op cannot begin in END. It needs start_i to drop for at least one cycle.
- Arithmetic edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No flag; the result wraps.
  - abs(0x80000000) is treated as unsigned 0x80000000.
- Simultaneous events: rst > annul_i > start_i. Inputs are ignored outside IDLE except start_i and annul_i.
- Operand latching: opdata*_i changes after the start edge have no effect.

Decomposition:
- defines.v gets the following:
  - State encodings DivFree, DivByZero, DivOn, DivEnd (2'b00..2'b11).
  - DivResultReady and DivResultNotReady.
  - DivStart and DivStop.
  - DoubleRegBus [63:0].
- Natural sub-module: div_step. It is combinational: a single compare/subtract iteration taking remainder, divisor and the incoming bit, and returning the new remainder and quotient bit. It is instantiated once and driven by the ON state.
- EX changes: add ALU_DIV_OP and ALU_DIVU_OP. Drive start_i, stallreq_from_ex, and hi/lo writes from this block.

Test Plan:
1. DIVU 100 / 7 -> ready_o rises 33 edges after start; result_o = 0x00000002_0000000E, div_zero_o=0.
2. DIV 0xFFFFFFF9 (-7) / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). DIV 7 / 0xFFFFFFFE -> 0x00000001_FFFFFFFD.
3. DIVU 5 / 0 -> ready_o rises 2 edges after start; result_o=0, div_zero_o=1. Dropping start_i returns to IDLE with ready_o=0 next edge.
4. DIV 1000 / 3 with annul_i pulsed at iteration 10 -> ready_o never rises and the state is IDLE. An immediate new DIVU 9 / 3 gives 0x00000000_00000003 in 33 edges.
5. rst asserted at iteration 15 -> next edge: ready_o=0, result_o=0, IDLE. Operand changes during ON do not alter the result of the next op.
6. DIV 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000. DIVU 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF. Holding start_i 5 extra cycles in END keeps result_o stable.
